// File: rtl/mem_port_arbiter.sv
// Shares one external memory port between instruction fetch and the load/store unit.
// One transaction in flight; data has priority, bounded by a fetch-starvation streak limit.
module mem_port_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_done,
  output logic [31:0] if_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [3:0]  d_wstrb,
  output logic        d_done,
  output logic [31:0] d_rdata,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic        mem_ready,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic        owner
);

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned SW = 4;
  localparam int unsigned CW = 4;
  localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic            mem_req_q, mem_req_d;
  logic            mem_we_q, mem_we_d;
  logic [AW-1:0]   mem_addr_q, mem_addr_d;
  logic [DW-1:0]   mem_wdata_q, mem_wdata_d;
  logic [SW-1:0]   mem_wstrb_q, mem_wstrb_d;
  logic            owner_q, owner_d;
  logic            if_done_q, if_done_d;
  logic            d_done_q, d_done_d;
  logic [DW-1:0]   if_rdata_q, if_rdata_d;
  logic [DW-1:0]   d_rdata_q, d_rdata_d;
  logic [CW-1:0]   streak_q, streak_d;

  logic            f_pend;
  logic            d_pend;
  logic            grant_f;
  logic            rsp_fire;

  // Next-state and output computation
  always_comb begin
    state_d     = state_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_wstrb_d = mem_wstrb_q;
    owner_d     = owner_q;
    if_rdata_d  = if_rdata_q;
    d_rdata_d   = d_rdata_q;
    streak_d    = streak_q;
    if_done_d   = 1'b0;
    d_done_d    = 1'b0;
    rsp_fire    = 1'b0;

    // A requester whose done is pulsing now still holds req; mask it to avoid re-issue
    f_pend  = if_req & ~if_done_q;
    d_pend  = d_req & ~d_done_q;
    grant_f = f_pend & (~d_pend | (streak_q == LIMIT));

    case (state_q)
      IDLE: begin
        if (f_pend | d_pend) begin
          state_d   = REQ;
          mem_req_d = 1'b1;
          owner_d   = ~grant_f;
          if (grant_f) begin
            mem_we_d    = 1'b0;
            mem_addr_d  = if_addr;
            mem_wdata_d = '0;
            mem_wstrb_d = '0;
            streak_d    = '0;
          end else begin
            mem_we_d    = d_we;
            mem_addr_d  = d_addr;
            mem_wdata_d = d_wdata;
            mem_wstrb_d = d_wstrb;
            if (!if_req) begin
              streak_d = '0;
            end else if (streak_q < LIMIT) begin
              streak_d = streak_q + CW'(1);
            end
          end
        end
      end
      REQ: begin
        if (mem_ready) begin
          mem_req_d = 1'b0;
          if (mem_we_q) begin
            d_done_d = 1'b1;
            state_d  = IDLE;
          end else if (mem_rvalid) begin
            rsp_fire = 1'b1;
            state_d  = IDLE;
          end else begin
            state_d = RESP;
          end
        end
      end
      RESP: begin
        if (mem_rvalid) begin
          rsp_fire = 1'b1;
          state_d  = IDLE;
        end
      end
      default: begin
        state_d   = IDLE;
        mem_req_d = 1'b0;
      end
    endcase

    // Read data goes back to whichever requester owns the transaction
    if (rsp_fire) begin
      if (owner_q) begin
        d_rdata_d = mem_rdata;
        d_done_d  = 1'b1;
      end else begin
        if_rdata_d = mem_rdata;
        if_done_d  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_wstrb_q <= '0;
      owner_q     <= 1'b0;
      if_done_q   <= 1'b0;
      d_done_q    <= 1'b0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
      streak_q    <= '0;
    end else begin
      state_q     <= state_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_wstrb_q <= mem_wstrb_d;
      owner_q     <= owner_d;
      if_done_q   <= if_done_d;
      d_done_q    <= d_done_d;
      if_rdata_q  <= if_rdata_d;
      d_rdata_q   <= d_rdata_d;
      streak_q    <= streak_d;
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_wstrb = mem_wstrb_q;
  assign owner     = owner_q;
  assign if_done   = if_done_q;
  assign d_done    = d_done_q;
  assign if_rdata  = if_rdata_q;
  assign d_rdata   = d_rdata_q;

endmodule
